// File: rtl/sign_narrow.sv
// Narrows signed IN_WIDTH-bit words to OUT_WIDTH-bit halfwords, flags words that
// do not fit, wraps or saturates them, and buffers results in a 2-entry FIFO.
module sign_narrow #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_sat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_ovf,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] ovf_count
);

    localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [OUT_WIDTH-1:0]        r_data0;
    logic [OUT_WIDTH-1:0]        r_data1;
    logic                        r_ovf0;
    logic                        r_ovf1;
    logic [1:0]                  r_count;
    logic [CNT_WIDTH-1:0]        r_ovf_count;

    logic [IN_WIDTH-OUT_WIDTH:0] w_upper;
    logic                        w_ovf;
    logic [OUT_WIDTH-1:0]        w_result;
    logic                        w_accept;
    logic                        w_pop;

    // The word fits when every bit from the halfword sign bit upward agrees.
    always_comb begin
        w_upper  = in_data[IN_WIDTH-1:OUT_WIDTH-1];
        w_ovf    = !((&w_upper) || !(|w_upper));
        w_result = in_data[OUT_WIDTH-1:0];
        if (w_ovf && in_sat) begin
            w_result = in_data[IN_WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end

    assign in_ready  = (r_count < 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign out_data  = r_data0;
    assign out_ovf   = r_ovf0;
    assign ovf_count = r_ovf_count;

    // Head lives in slot 0; a pop that empties the buffer leaves slot 0 untouched
    // so the output holds its last value while empty.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_ovf0  <= 1'b0;
            r_ovf1  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            case ({w_accept, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_data0 <= w_result;
                        r_ovf0  <= w_ovf;
                    end else begin
                        r_data1 <= w_result;
                        r_ovf1  <= w_ovf;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_data0 <= r_data1;
                        r_ovf0  <= r_ovf1;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_data0 <= w_result;
                        r_ovf0  <= w_ovf;
                    end else begin
                        r_data0 <= r_data1;
                        r_ovf0  <= r_ovf1;
                        r_data1 <= w_result;
                        r_ovf1  <= w_ovf;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Clear takes priority over a coincident increment; the count never wraps.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ovf_count <= '0;
        end else if (cnt_clr) begin
            r_ovf_count <= '0;
        end else if (w_accept && w_ovf && (r_ovf_count != CNT_MAX)) begin
            r_ovf_count <= r_ovf_count + 1'b1;
        end
    end

endmodule
